sha256_msg_padder: RTL and testbench

- Streaming pre-processor directly upstream of the SHA-256 hash core.
- Accepts a message as 32-bit big-endian words on a valid/ready stream and emits the fully padded message, also as 32-bit words.
- Padding rule: append 0x80000000, then zero words, then a 64-bit bit-length, so the output is a whole number of 16-word (512-bit) blocks.
- Block/message boundary flags let the core start message scheduling without doing padding itself.

---
 rtl/sha256_msg_padder_if.sv | 23 ++
 rtl/sha256_msg_padder.sv | 129 ++++++++++++
 tb/tb_sha256_msg_padder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Stream bundle around the SHA-256 message padder: message words in, padded words out.
// The environment (source + sink) takes the master view, the padder the slave view.
interface sha256_msg_padder_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_block_last;
   logic        out_msg_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_block_last, out_msg_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_block_last, out_msg_last
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 pre-processor: forwards message words, then appends 0x80000000,
// zero fill and the 64-bit bit length so the output is a whole number of 512-bit blocks.
module sha256_msg_padder #(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   sha256_msg_padder_if.slave bus,
   output logic               busy,
   output logic               overflow
);

   typedef enum logic [2:0] {PASS, PAD80, ZERO, LEN_HI, LEN_LO, DONE} state_t;

   // Last count value at which another non-final word is still accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

   state_t           state, state_nxt;
   logic [3:0]       pos;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      len;
   logic             can_load;
   logic             in_fire;
   logic             out_fire;
   logic             load;
   logic [31:0]      load_data;
   logic             load_msg_last;
   logic             ovf_nxt;

   assign can_load     = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = (state == PASS) && can_load && !reset;
   assign in_fire      = bus.in_valid && bus.in_ready;
   assign out_fire     = bus.out_valid && bus.out_ready;
   assign len          = 64'({cnt, 5'b0});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= PASS;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      load          = 1'b0;
      load_data     = '0;
      load_msg_last = 1'b0;
      ovf_nxt       = 1'b0;
      case (state)
         PASS: begin
            if (in_fire) begin
               load      = 1'b1;
               load_data = bus.in_data;
               if (bus.in_last) begin
                  state_nxt = PAD80;
               end else if (cnt == CNT_LAST) begin
                  ovf_nxt   = 1'b1;
                  state_nxt = PAD80;
               end
            end
         end
         PAD80: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = 32'h8000_0000;
               state_nxt = (pos == 4'd13) ? LEN_HI : ZERO;
            end
         end
         ZERO: begin
            if (can_load) begin
               load = 1'b1;
               if (pos == 4'd13) state_nxt = LEN_HI;
            end
         end
         LEN_HI: begin
            if (can_load) begin
               load      = 1'b1;
               load_data = len[63:32];
               state_nxt = LEN_LO;
            end
         end
         LEN_LO: begin
            if (can_load) begin
               load          = 1'b1;
               load_data     = len[31:0];
               load_msg_last = 1'b1;
               state_nxt     = DONE;
            end
         end
         DONE: begin
            if (out_fire) state_nxt = PASS;
         end
         default: state_nxt = PASS;
      endcase
   end

   // Output register stage: loads when empty or draining, otherwise holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.out_valid      <= 1'b0;
         bus.out_data       <= '0;
         bus.out_block_last <= 1'b0;
         bus.out_msg_last   <= 1'b0;
         pos                <= '0;
         cnt                <= '0;
         busy               <= 1'b0;
         overflow           <= 1'b0;
      end else begin
         overflow <= ovf_nxt;
         if (load) begin
            bus.out_valid      <= 1'b1;
            bus.out_data       <= load_data;
            bus.out_block_last <= (pos == 4'd15);
            bus.out_msg_last   <= load_msg_last;
            pos                <= pos + 4'd1;
         end else if (out_fire) begin
            bus.out_valid <= 1'b0;
         end
         if (in_fire) begin
            cnt  <= cnt + CNT_W'(1);
            busy <= 1'b1;
         end
         if ((state == DONE) && out_fire) begin
            cnt  <= '0;
            busy <= 1'b0;
            pos  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a CNT_W=16 instance for the main traffic
// and a CNT_W=4 instance for the maximum-length truncation case.
module tb_sha256_msg_padder;

   typedef struct packed {
      logic [31:0] d;
      logic        bl;
      logic        ml;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        sel;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_ready;
   logic        rdy_mode;
   logic        busy_a, busy_b, ovf_a, ovf_b;

   logic        o_valid, o_in_ready, o_bl, o_ml, o_busy, o_ovf;
   logic [31:0] o_data;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   sha256_msg_padder_if bus_a ();
   sha256_msg_padder_if bus_b ();

   sha256_msg_padder #(.CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a), .overflow(ovf_a)
   );

   sha256_msg_padder #(.CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b), .overflow(ovf_b)
   );

   assign bus_a.in_valid  = in_valid & ~sel;
   assign bus_a.in_data   = in_data;
   assign bus_a.in_last   = in_last;
   assign bus_a.out_ready = sel ? 1'b1 : out_ready;
   assign bus_b.in_valid  = in_valid & sel;
   assign bus_b.in_data   = in_data;
   assign bus_b.in_last   = in_last;
   assign bus_b.out_ready = sel ? out_ready : 1'b1;

   assign o_valid    = sel ? bus_b.out_valid      : bus_a.out_valid;
   assign o_in_ready = sel ? bus_b.in_ready       : bus_a.in_ready;
   assign o_data     = sel ? bus_b.out_data       : bus_a.out_data;
   assign o_bl       = sel ? bus_b.out_block_last : bus_a.out_block_last;
   assign o_ml       = sel ? bus_b.out_msg_last   : bus_a.out_msg_last;
   assign o_busy     = sel ? busy_b : busy_a;
   assign o_ovf      = sel ? ovf_b  : ovf_a;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
   endtask

   // Reference padding: message, 0x80000000, zeros up to index 14 mod 16, 64-bit length.
   task automatic push_expect(input int m, input logic [31:0] base);
      int          total;
      logic [63:0] len;
      exp_t        e;
      total = ((m + 18) / 16) * 16;
      len   = 64'(m) * 64'd32;
      for (int k = 0; k < total; k++) begin
         if (k < m)               e.d = base + 32'(k);
         else if (k == m)         e.d = 32'h8000_0000;
         else if (k == total - 2) e.d = len[63:32];
         else if (k == total - 1) e.d = len[31:0];
         else                     e.d = 32'h0;
         e.bl = (k % 16 == 15);
         e.ml = (k == total - 1);
         exp_q.push_back(e);
      end
   endtask

   // Monitor: compare the presented word with the scoreboard head; pop on transfer.
   always @(negedge clk) begin
      if (!reset && o_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", o_data, 32'hxxxx_xxxx);
         end else begin
            check("out_data", o_data, exp_q[0].d);
            check("out_block_last", 32'(o_bl), 32'(exp_q[0].bl));
            check("out_msg_last", 32'(o_ml), 32'(exp_q[0].ml));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode) out_ready = ~out_ready;
         else          out_ready = 1'b1;
      end
   end

   task automatic send_msg(input int n, input logic [31:0] base, input bit gaps,
                           input bit nolast, input int stop_after);
      int   cw, maxw, m, b;
      logic lst, xovf;
      cw   = sel ? 4 : 16;
      maxw = (1 << cw) - 1;
      m    = (nolast && n > maxw) ? maxw : n;
      push_expect(m, base);
      for (int i = 0; i < m; i++) begin
         if (stop_after != 0 && i == stop_after) break;
         if (gaps && (i % 3 == 1)) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         lst      = !nolast && (i == n - 1);
         xovf     = (i == maxw - 1) && !lst;
         in_valid = 1'b1;
         in_data  = base + 32'(i);
         in_last  = lst;
         b = 0;
         forever begin
            @(negedge clk);
            if (o_in_ready) break;
            b++;
            if (b > 200) break;
         end
         if (b > 200) begin
            check("in_ready_timeout", 32'(b), 32'd0);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check("out_valid_latency", 32'(o_valid), 32'd1);
         check("overflow", 32'(o_ovf), 32'(xovf));
         if (i == 0) check("busy_set", 32'(o_busy), 32'd1);
         if (xovf) begin
            @(posedge clk);
            #1;
            check("overflow_pulse", 32'(o_ovf), 32'd0);
         end
      end
   endtask

   task automatic wait_idle();
      int b;
      b = 0;
      while ((exp_q.size() != 0 || o_valid) && b < 500) begin
         @(posedge clk);
         #1;
         b++;
      end
      check("drain_cycles_exhausted", 32'(b >= 500), 32'd0);
      check("busy_idle", 32'(o_busy), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      sel      = 1'b0;
      rdy_mode = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      #3;
      check("rst_in_ready", 32'(o_in_ready), 32'd0);
      check("rst_out_valid", 32'(o_valid), 32'd0);
      check("rst_out_data", o_data, 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(o_in_ready), 32'd1);

      // single word, 13 words (pad at position 13), 14 words (extra block)
      send_msg(1, 32'h6162_6364, 1'b0, 1'b0, 0);
      wait_idle();
      send_msg(13, 32'h0000_0001, 1'b0, 1'b0, 0);
      wait_idle();
      send_msg(14, 32'hA000_0000, 1'b0, 1'b0, 0);
      wait_idle();

      // 20 words with back-pressure toggling and input gaps
      rdy_mode = 1'b1;
      send_msg(20, 32'h0100_0000, 1'b1, 1'b0, 0);
      wait_idle();
      rdy_mode = 1'b0;
      @(posedge clk);
      #1;

      // reset after 5 of 10 words, then a fresh single-word message
      send_msg(10, 32'h0000_0100, 1'b0, 1'b0, 5);
      reset = 1'b1;
      #1;
      check("midrst_in_ready", 32'(o_in_ready), 32'd0);
      check("midrst_out_valid", 32'(o_valid), 32'd0);
      check("midrst_out_data", o_data, 32'd0);
      check("midrst_block_last", 32'(o_bl), 32'd0);
      check("midrst_msg_last", 32'(o_ml), 32'd0);
      check("midrst_busy", 32'(o_busy), 32'd0);
      check("midrst_overflow", 32'(o_ovf), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_release_in_ready", 32'(o_in_ready), 32'd1);
      send_msg(1, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
      wait_idle();

      // maximum-length truncation on the CNT_W=4 instance
      sel = 1'b1;
      #1;
      send_msg(16, 32'h0000_5000, 1'b0, 1'b1, 0);
      wait_idle();
      sel = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
